// File: rtl/address_update_r.sv
// Read-side Sobel window address generator: three word reads per interior pixel, valid/ack handshake.
// Optional walk freeze input enabled with `define ADDR_R_PAUSE_EN.
module address_update_r (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [15:0] length,
   input  logic [15:0] width,
   input  logic [31:0] addr,
   input  logic        start,
   input  logic        rd_ack,
   output logic [31:0] curr_addr,
   output logic        addr_valid,
   output logic        win_last,
   output logic [15:0] pix_row,
   output logic [15:0] pix_col,
   output logic        busy,
   output logic        done
`ifdef ADDR_R_PAUSE_EN
   ,
   input  logic        pause
`endif
);

   localparam int unsigned DIM_W  = 16;
   localparam int unsigned ADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state, state_d;
   logic [DIM_W-1:0]    len_q, len_d;
   logic [DIM_W-1:0]    wid_q, wid_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [1:0]          k_q, k_d;
   logic [ADDR_W-1:0]   curr_addr_d;
   logic                addr_valid_d;
   logic                win_last_d;
   logic [DIM_W-1:0]    pix_row_d, pix_col_d;
   logic                busy_d;
   logic                done_d;
   logic                pause_i;
   logic                accept;
   logic [ADDR_W-1:0]   wid_ext;

`ifdef ADDR_R_PAUSE_EN
   assign pause_i = pause;
`else
   assign pause_i = 1'b0;
`endif

   assign wid_ext = {{(ADDR_W-DIM_W){1'b0}}, wid_q};
   assign accept  = addr_valid && rd_ack && !pause_i;

   // Next-state and next-output logic; window row offsets are accumulated, never multiplied
   always_comb begin
      state_d      = state;
      len_d        = len_q;
      wid_d        = wid_q;
      base_d       = base_q;
      k_d          = k_q;
      curr_addr_d  = curr_addr;
      addr_valid_d = addr_valid;
      win_last_d   = 1'b0;
      pix_row_d    = pix_row;
      pix_col_d    = pix_col;
      done_d       = 1'b0;

      case (state)
         IDLE: begin
            addr_valid_d = 1'b0;
            if (start) begin
               if (length >= DIM_W'(3) && width >= DIM_W'(3)) begin
                  state_d      = FETCH;
                  len_d        = length;
                  wid_d        = width;
                  base_d       = addr;
                  k_d          = 2'd0;
                  pix_row_d    = DIM_W'(1);
                  pix_col_d    = DIM_W'(1);
                  curr_addr_d  = addr;
                  addr_valid_d = 1'b1;
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end

         FETCH: begin
            addr_valid_d = !pause_i;
            if (accept) begin
               if (k_q != 2'd2) begin
                  k_d         = 2'(k_q + 2'd1);
                  curr_addr_d = ADDR_W'(curr_addr + wid_ext);
               end else begin
                  win_last_d = 1'b1;
                  k_d        = 2'd0;
                  if (pix_col < DIM_W'(wid_q - DIM_W'(2))) begin
                     pix_col_d   = DIM_W'(pix_col + DIM_W'(1));
                     base_d      = ADDR_W'(base_q + ADDR_W'(1));
                     curr_addr_d = ADDR_W'(base_q + ADDR_W'(1));
                  end else if (pix_row < DIM_W'(len_q - DIM_W'(2))) begin
                     // Skipping the 2-pixel border lands base on the next row start
                     pix_row_d   = DIM_W'(pix_row + DIM_W'(1));
                     pix_col_d   = DIM_W'(1);
                     base_d      = ADDR_W'(base_q + ADDR_W'(3));
                     curr_addr_d = ADDR_W'(base_q + ADDR_W'(3));
                  end else begin
                     state_d      = DONE;
                     done_d       = 1'b1;
                     addr_valid_d = 1'b0;
                  end
               end
            end
         end

         DONE: begin
            state_d      = IDLE;
            addr_valid_d = 1'b0;
         end

         default: begin
            state_d      = IDLE;
            addr_valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and registered outputs
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state      <= IDLE;
         len_q      <= '0;
         wid_q      <= '0;
         base_q     <= '0;
         k_q        <= '0;
         curr_addr  <= '0;
         addr_valid <= 1'b0;
         win_last   <= 1'b0;
         pix_row    <= '0;
         pix_col    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_d;
         len_q      <= len_d;
         wid_q      <= wid_d;
         base_q     <= base_d;
         k_q        <= k_d;
         curr_addr  <= curr_addr_d;
         addr_valid <= addr_valid_d;
         win_last   <= win_last_d;
         pix_row    <= pix_row_d;
         pix_col    <= pix_col_d;
         busy       <= busy_d;
         done       <= done_d;
      end
   end

endmodule
